// File: rtl/regression_train_controller_pkg.sv
// Shared definitions for the regression training sequencer: state encoding,
// default sizing and the checker watchdog limit.
package regression_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    CLEAR       = 4'd1,
    LOAD        = 4'd2,
    DRAIN       = 4'd3,
    UPDATE      = 4'd4,
    CHECK_START = 4'd5,
    CHECK_WAIT  = 4'd6,
    DECIDE      = 4'd7,
    FINISH      = 4'd8
  } state_t;

  localparam int DEF_N_SAMPLES  = 150;
  localparam int DEF_MAX_EPOCHS = 50;

  localparam int              WD_W     = 10;
  localparam logic [WD_W-1:0] WD_LIMIT = 10'd1023;

endpackage

// File: rtl/regression_train_controller_if.sv
// Handshake bundle between the training sequencer (master) and the
// datapath / error-checker / host side (slave).
interface regression_train_controller_if #(
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 8
);
  logic               start;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic               acc_clr;
  logic               acc_en;
  logic               coef_ld;
  logic               ec_en;
  logic               ec_done;
  logic               err_below;
  logic               busy;
  logic               done;
  logic               converged;
  logic [EPOCH_W-1:0] epoch;
  logic               timeout;

  modport master (
    input  start, ec_done, err_below,
    output mem_rd, mem_addr, acc_clr, acc_en, coef_ld, ec_en,
           busy, done, converged, epoch, timeout
  );

  modport slave (
    output start, ec_done, err_below,
    input  mem_rd, mem_addr, acc_clr, acc_en, coef_ld, ec_en,
           busy, done, converged, epoch, timeout
  );
endinterface

// File: rtl/regression_train_controller_ctrl_counter.sv
// Up-counter with synchronous clear (priority over increment) and a
// terminal-count flag that is high while the count equals TERM.
module ctrl_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TERM = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         tc
);

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (inc) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

  assign tc = (q == TERM);

endmodule

// File: rtl/regression_train_controller.sv
// Training-loop sequencer: per epoch clear, stream samples, update coefficients,
// run the error checker. Optional checker watchdog: REGRESSION_TRAIN_CTRL_TIMEOUT_EN.
module regression_train_controller
  import regression_pkg::*;
#(
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int ADDR_W     = 8,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = DEF_MAX_EPOCHS
) (
  input logic                          clk,
  input logic                          rst,
  regression_train_controller_if.master bus
);

  state_t state;
  logic   wait_first;
  logic   addr_clr, addr_inc, addr_tc;
  logic   epoch_clr, epoch_inc, epoch_tc;

  assign addr_clr  = (state == CLEAR);
  assign addr_inc  = (state == LOAD) && !addr_tc;
  assign epoch_clr = (state == IDLE) && bus.start;
  assign epoch_inc = (state == DECIDE) && !bus.err_below && !epoch_tc;

  // The address counter doubles as mem_addr; it parks on the last address after LOAD.
  ctrl_counter #(.W(ADDR_W), .TERM(ADDR_W'(N_SAMPLES - 1))) u_addr (
    .clk(clk), .rst(rst), .clr(addr_clr), .inc(addr_inc),
    .q(bus.mem_addr), .tc(addr_tc)
  );

  ctrl_counter #(.W(EPOCH_W), .TERM(EPOCH_W'(MAX_EPOCHS - 1))) u_epoch (
    .clk(clk), .rst(rst), .clr(epoch_clr), .inc(epoch_inc),
    .q(bus.epoch), .tc(epoch_tc)
  );

`ifdef REGRESSION_TRAIN_CTRL_TIMEOUT_EN
  logic            timeout_flag;
  logic            wd_clr, wd_inc, wd_tc;
  logic [WD_W-1:0] wd_cnt;

  assign wd_clr = (state == CHECK_START);
  assign wd_inc = (state == CHECK_WAIT);

  // tc one below the limit so the increment that reaches the limit is the one that fires.
  ctrl_counter #(.W(WD_W), .TERM(WD_LIMIT - 10'd1)) u_wd (
    .clk(clk), .rst(rst), .clr(wd_clr), .inc(wd_inc),
    .q(wd_cnt), .tc(wd_tc)
  );

  assign bus.timeout = timeout_flag;
`else
  assign bus.timeout = 1'b0;
`endif

  // Sequencer state and registered strobes/status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_first    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.acc_clr   <= 1'b0;
      bus.acc_en    <= 1'b0;
      bus.coef_ld   <= 1'b0;
      bus.ec_en     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.converged <= 1'b0;
`ifdef REGRESSION_TRAIN_CTRL_TIMEOUT_EN
      timeout_flag  <= 1'b0;
`endif
    end else begin
      bus.mem_rd  <= 1'b0;
      bus.acc_clr <= 1'b0;
      bus.coef_ld <= 1'b0;
      bus.ec_en   <= 1'b0;
      bus.acc_en  <= bus.mem_rd;
      wait_first  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= CLEAR;
            bus.acc_clr   <= 1'b1;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.converged <= 1'b0;
`ifdef REGRESSION_TRAIN_CTRL_TIMEOUT_EN
            timeout_flag  <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          state      <= LOAD;
          bus.mem_rd <= 1'b1;
        end
        LOAD: begin
          if (addr_tc) begin
            state <= DRAIN;
          end else begin
            state      <= LOAD;
            bus.mem_rd <= 1'b1;
          end
        end
        DRAIN: begin
          state       <= UPDATE;
          bus.coef_ld <= 1'b1;
        end
        UPDATE: begin
          state     <= CHECK_START;
          bus.ec_en <= 1'b1;
        end
        CHECK_START: begin
          state      <= CHECK_WAIT;
          wait_first <= 1'b1;
        end
        CHECK_WAIT: begin
          // ec_done may still show the previous idle level in the first cycle.
          if (!wait_first && bus.ec_done) begin
            state <= DECIDE;
`ifdef REGRESSION_TRAIN_CTRL_TIMEOUT_EN
          end else if (wd_tc) begin
            state        <= FINISH;
            timeout_flag <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
`endif
          end else begin
            state <= CHECK_WAIT;
          end
        end
        DECIDE: begin
          if (bus.err_below) begin
            state         <= FINISH;
            bus.converged <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
          end else if (epoch_tc) begin
            state    <= FINISH;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state       <= CLEAR;
            bus.acc_clr <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regression_train_controller.sv
// Directed bench for regression_train_controller (N_SAMPLES=4, MAX_EPOCHS=3);
// the checker model answers ec_done three cycles after ec_en.
module tb_regression_train_controller;

  logic clk;
  logic rst;
  logic hold;
  int   ec_cnt;
  int   checks;
  int   errors;

  int   rd_cyc[$];
  int   rd_addr[$];
  int   acc_cyc[$];
  int   n_coef, n_ec, n_clr, done_cyc;
  logic d_at1, c_at1;
  logic fin_conv, fin_busy, fin_to;
  int   fin_epoch;

  regression_train_controller_if #(.ADDR_W(8), .EPOCH_W(8)) bus ();

  regression_train_controller #(
    .N_SAMPLES(4), .ADDR_W(8), .EPOCH_W(8), .MAX_EPOCHS(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Error-checker model: busy for three cycles after each ec_en pulse
  always @(negedge clk) begin
    if (rst) begin
      bus.ec_done = 1'b1;
      ec_cnt = 0;
    end else if (bus.ec_en) begin
      bus.ec_done = 1'b0;
      ec_cnt = 3;
    end else if (ec_cnt > 0) begin
      ec_cnt = ec_cnt - 1;
      if (ec_cnt == 0 && !hold) bus.ec_done = 1'b1;
    end
  end

  task automatic run_until_done(input int limit, input int inject);
    rd_cyc.delete();
    rd_addr.delete();
    acc_cyc.delete();
    n_coef = 0; n_ec = 0; n_clr = 0; done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int s = 1; s <= limit; s++) begin
      @(negedge clk);
      bus.start = (s == inject);
      if (s == 1) begin d_at1 = bus.done; c_at1 = bus.converged; end
      if (bus.mem_rd) begin rd_cyc.push_back(s); rd_addr.push_back(int'(bus.mem_addr)); end
      if (bus.acc_en) acc_cyc.push_back(s);
      if (bus.coef_ld) n_coef++;
      if (bus.ec_en) n_ec++;
      if (bus.acc_clr) n_clr++;
      if (bus.done) begin
        done_cyc  = s;
        fin_epoch = int'(bus.epoch);
        fin_conv  = bus.converged;
        fin_busy  = bus.busy;
        fin_to    = bus.timeout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.mem_rd, bus.acc_clr, bus.acc_en, bus.coef_ld, bus.ec_en,
         bus.busy, bus.done, bus.converged, bus.timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000000000", {bus.mem_rd, bus.acc_clr,
               bus.acc_en, bus.coef_ld, bus.ec_en, bus.busy, bus.done, bus.converged, bus.timeout});
    end
    checks++;
    if (bus.mem_addr !== 8'd0) begin
      errors++; $display("FAIL reset_mem_addr got %0d want 0", bus.mem_addr);
    end
    checks++;
    if (bus.epoch !== 8'd0) begin
      errors++; $display("FAIL reset_epoch got %0d want 0", bus.epoch);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_converge_first();
    bus.err_below = 1'b1;
    run_until_done(60, -1);
    checks++;
    if (done_cyc != 13) begin errors++; $display("FAIL conv_done_cycle got %0d want 13", done_cyc); end
    checks++;
    if (rd_cyc.size() != 4) begin errors++; $display("FAIL conv_rd_count got %0d want 4", rd_cyc.size()); end
    for (int i = 0; i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] != 2 + i || rd_addr[i] != i) begin
        errors++;
        $display("FAIL conv_rd_%0d got cyc %0d addr %0d want cyc %0d addr %0d", i, rd_cyc[i], rd_addr[i], 2 + i, i);
      end
    end
    checks++;
    if (acc_cyc.size() != 4) begin errors++; $display("FAIL conv_acc_count got %0d want 4", acc_cyc.size()); end
    for (int i = 0; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] != 3 + i) begin
        errors++; $display("FAIL conv_acc_lag_%0d got cyc %0d want %0d", i, acc_cyc[i], 3 + i);
      end
    end
    checks++;
    if (n_coef != 1 || n_ec != 1 || n_clr != 1) begin
      errors++; $display("FAIL conv_pulses got coef %0d ec %0d clr %0d want 1 1 1", n_coef, n_ec, n_clr);
    end
    checks++;
    if (fin_conv !== 1'b1 || fin_epoch != 0 || fin_busy !== 1'b0 || fin_to !== 1'b0) begin
      errors++;
      $display("FAIL conv_final got conv %b epoch %0d busy %b to %b want 1 0 0 0", fin_conv, fin_epoch, fin_busy, fin_to);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.converged !== 1'b1 || bus.epoch !== 8'd0) begin
      errors++;
      $display("FAIL conv_hold got done %b conv %b epoch %0d want 1 1 0", bus.done, bus.converged, bus.epoch);
    end
  endtask

  task automatic test_epoch_limit();
    bus.err_below = 1'b0;
    run_until_done(100, -1);
    checks++;
    if (d_at1 !== 1'b0 || c_at1 !== 1'b0) begin
      errors++; $display("FAIL limit_status_clear got done %b conv %b want 0 0", d_at1, c_at1);
    end
    checks++;
    if (done_cyc != 37) begin errors++; $display("FAIL limit_done_cycle got %0d want 37", done_cyc); end
    checks++;
    if (n_coef != 3 || n_ec != 3 || n_clr != 3) begin
      errors++; $display("FAIL limit_pulses got coef %0d ec %0d clr %0d want 3 3 3", n_coef, n_ec, n_clr);
    end
    checks++;
    if (rd_cyc.size() != 12) begin
      errors++; $display("FAIL limit_rd_count got %0d want 12", rd_cyc.size());
    end else begin
      checks++;
      if (rd_cyc[4] != 14 || rd_addr[4] != 0) begin
        errors++; $display("FAIL limit_epoch1_rd got cyc %0d addr %0d want 14 0", rd_cyc[4], rd_addr[4]);
      end
    end
    checks++;
    if (fin_conv !== 1'b0 || fin_epoch != 2) begin
      errors++; $display("FAIL limit_final got conv %b epoch %0d want 0 2", fin_conv, fin_epoch);
    end
  endtask

  task automatic test_reset_mid_load();
    int found;
    found = 0;
    bus.err_below = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_rd && bus.mem_addr == 8'd2) begin found = 1; break; end
    end
    checks++;
    if (found != 1) begin errors++; $display("FAIL rst_reach_addr2 got %0d want 1", found); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_rd, bus.acc_clr, bus.acc_en, bus.coef_ld, bus.ec_en, bus.busy, bus.done} !== 7'b0) begin
      errors++; $display("FAIL rst_abort_now got %b want 0000000", {bus.mem_rd, bus.acc_clr,
               bus.acc_en, bus.coef_ld, bus.ec_en, bus.busy, bus.done});
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_rd, bus.acc_clr, bus.acc_en, bus.coef_ld, bus.ec_en, bus.busy, bus.done,
         bus.converged, bus.timeout, bus.mem_addr, bus.epoch} !== 25'b0) begin
      errors++; $display("FAIL rst_abort_next got addr %0d epoch %0d busy %b want 0 0 0",
                         bus.mem_addr, bus.epoch, bus.busy);
    end
    rst = 1'b0;
    run_until_done(100, -1);
    checks++;
    if (rd_cyc.size() == 0 || rd_cyc[0] != 2 || rd_addr[0] != 0) begin
      errors++; $display("FAIL rst_restart got %0d reads want first at cyc 2 addr 0", rd_cyc.size());
    end
    checks++;
    if (done_cyc != 37 || fin_epoch != 2) begin
      errors++; $display("FAIL rst_restart_done got cyc %0d epoch %0d want 37 2", done_cyc, fin_epoch);
    end
  endtask

  task automatic test_start_during_check();
    bus.err_below = 1'b0;
    run_until_done(100, 10);
    checks++;
    if (done_cyc != 37 || fin_epoch != 2) begin
      errors++; $display("FAIL busy_start_done got cyc %0d epoch %0d want 37 2", done_cyc, fin_epoch);
    end
    checks++;
    if (n_coef != 3 || n_ec != 3 || n_clr != 3 || rd_cyc.size() != 12) begin
      errors++; $display("FAIL busy_start_pulses got coef %0d ec %0d clr %0d rd %0d want 3 3 3 12",
                         n_coef, n_ec, n_clr, rd_cyc.size());
    end
  endtask

  task automatic test_no_ec_done();
    hold = 1'b1;
    bus.err_below = 1'b0;
    run_until_done(1100, -1);
`ifdef REGRESSION_TRAIN_CTRL_TIMEOUT_EN
    checks++;
    if (done_cyc != 1032) begin errors++; $display("FAIL wd_done_cycle got %0d want 1032", done_cyc); end
    checks++;
    if (fin_to !== 1'b1 || fin_conv !== 1'b0 || fin_epoch != 0) begin
      errors++; $display("FAIL wd_final got to %b conv %b epoch %0d want 1 0 0", fin_to, fin_conv, fin_epoch);
    end
`else
    checks++;
    if (done_cyc != -1) begin errors++; $display("FAIL wait_forever got done at %0d want none", done_cyc); end
    checks++;
    if (bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin
      errors++; $display("FAIL wait_forever_state got busy %b to %b want 1 0", bus.busy, bus.timeout);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    hold = 1'b0;
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.err_below = 1'b0;
    test_reset();
    test_converge_first();
    test_epoch_limit();
    test_reset_mid_load();
    test_start_during_check();
    test_no_ec_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regression_train_controller.md
# regression_train_controller

Top-level sequencer for the linear-regression training loop. Each epoch it streams every sample from the data memory into the accumulator datapath, loads the updated coefficients, and launches the error checker. It repeats until the error checker reports convergence or the epoch limit is reached. It sits above the datapath and the error-checker controller and is the only block driving their enables.

## Interface
- N_SAMPLES, 150: samples per epoch, ≥1
- ADDR_W, 8: data-memory address width, 2^ADDR_W ≥ N_SAMPLES
- EPOCH_W, 8: epoch counter width
- MAX_EPOCHS, 50: epoch limit, 1..2^EPOCH_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse that begins training
- mem_rd  out  1  data-memory read strobe
- mem_addr  out  ADDR_W  sample address
- acc_clr  out  1  clear accumulators, one cycle
- acc_en  out  1  accumulate the current memory data
- coef_ld  out  1  load updated coefficients, one cycle
- ec_en  out  1  error-checker enable, one-cycle pulse
- ec_done  in  1  error checker idle/finished
- err_below  in  1  error under threshold, valid while ec_done=1
- busy  out  1  training in progress
- done  out  1  training finished, level
- converged  out  1  finished by err_below, not by the epoch limit
- epoch  out  EPOCH_W  current/final epoch index
- timeout  out  1  checker watchdog fired (see Configuration)

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, UPDATE, CHECK_START, CHECK_WAIT, DECIDE, FINISH.
- IDLE: on start=1, clear done/converged/timeout, set epoch=0, go to CLEAR.
- CLEAR: acc_clr=1, address counter=0, go to LOAD.
- LOAD: mem_rd=1, mem_addr=counter, counter++. At counter==N_SAMPLES-1, go to DRAIN.
- acc_en is mem_rd delayed one cycle (memory read latency is 1). It is high in the LOAD cycles after the first, plus DRAIN.
- DRAIN: last acc_en cycle, then go to UPDATE.
- UPDATE: coef_ld=1, then go to CHECK_START.
- CHECK_START: ec_en=1, then go to CHECK_WAIT.
- CHECK_WAIT: ec_done is ignored on the first cycle. After that, wait for ec_done=1, then go to DECIDE.
- DECIDE: sample err_below.
  - err_below=1: converged=1, go to FINISH.
  - err_below=0 and epoch==MAX_EPOCHS-1: go to FINISH with converged=0.
  - Otherwise: epoch++, go to CLEAR.
- FINISH: done=1 and busy=0, go to IDLE. done, converged and epoch hold until the next start.
- busy=1 in every state except IDLE and FINISH.
- start while busy is ignored.
- Epoch arithmetic is unsigned. epoch never wraps, because the limit is checked before increment.

## Timing
- Reset values:
  - state IDLE, counters 0.
  - All outputs 0, including mem_addr, epoch, done, converged and timeout.
- Reset is asynchronous. Asserting it mid-operation aborts at once, with no coef_ld or ec_en glitch.
- Latency from start to the first mem_rd is 2 cycles (IDLE→CLEAR→LOAD).
- Cycles per epoch = N_SAMPLES + 5 + (checker cycles spent in CHECK_WAIT).
- N_SAMPLES=1: LOAD lasts one cycle and DRAIN follows directly.
- All strobes are registered Moore outputs. None is combinational from an input.

## Configuration
- Macro: REGRESSION_TRAIN_CTRL_TIMEOUT_EN.
- With the macro defined, a 10-bit watchdog counts CHECK_WAIT cycles.
  - If it reaches 1023 without ec_done, set timeout=1 and go to FINISH with converged=0.
  - The watchdog clears on each entry to CHECK_WAIT.
- Without the macro, there is no watchdog logic and timeout is tied to 0.

## Structure
- Package regression_pkg holds:
  - the state encoding constants (4-bit);
  - the default values for N_SAMPLES and MAX_EPOCHS;
  - the watchdog limit.
- Sub-module ctrl_counter: parameterised up-counter with clr, inc and a terminal-count output. It is instantiated for the sample address, the epoch and the watchdog.

## Test plan
- Setup for all cases: N_SAMPLES=4, MAX_EPOCHS=3. The model answers ec_done 3 cycles after ec_en.
- Convergence on the first epoch: start, err_below=1 → mem_addr 0,1,2,3 on consecutive cycles, acc_en 4 cycles lagging by 1, one coef_ld, one ec_en; then done=1, converged=1, epoch=0.
- Epoch limit: err_below always 0 → exactly 3 coef_ld and 3 ec_en pulses; done=1, converged=0, epoch=2.
- Reset mid-LOAD at mem_addr=2 → next cycle all outputs 0 and busy=0. A new start restarts at mem_addr=0.
- start pulsed during CHECK_WAIT → ignored; epoch count and sequence unchanged.
- Macro defined and ec_done held 0 → timeout=1 at CHECK_WAIT cycle 1023, then done=1, converged=0. Without the macro, the controller waits indefinitely.
